// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, row constants and index helpers for the keypad scanner
package keypad_pkg;

  localparam int KEY_W = 4;

  localparam logic [3:0] ROW_IDLE = 4'b1111;
  localparam logic [3:0] ROW0     = 4'b1000;
  localparam logic [3:0] ROW1     = 4'b0100;
  localparam logic [3:0] ROW2     = 4'b0010;
  localparam logic [3:0] ROW3     = 4'b0001;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DEBOUNCE,
    REPORT,
    RELEASE
  } scan_state_t;

  // Rows and columns share the same index-to-pattern mapping: index 0 is the MSB.
  function automatic logic [3:0] idx_onehot(input logic [1:0] idx);
    logic [3:0] pat;
    case (idx)
      2'd0:    pat = ROW0;
      2'd1:    pat = ROW1;
      2'd2:    pat = ROW2;
      default: pat = ROW3;
    endcase
    return pat;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b1000: idx = 2'd0;
      4'b0100: idx = 2'd1;
      4'b0010: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// rtl/keypad_col_sync.sv - two-flop synchronizer for the asynchronous column returns
module keypad_col_sync (
  input  logic       clk_sec,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] col_s
);

  logic [3:0] meta;

  always_ff @(posedge clk_sec) begin
    if (!rst_n) begin
      meta  <= '0;
      col_s <= '0;
    end else begin
      meta  <= col;
      col_s <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad row scanner, debouncer, encoder and key handshake
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYC   = 3,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic             clk_sec,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [3:0]       col,
  output logic [3:0]       row,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_held,
  output logic             overrun
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [7:0] DEB_LAST    = 8'(DEBOUNCE_CYC - 1);

  scan_state_t      state, state_nxt;
  logic [3:0]       col_s;
  logic [1:0]       r_idx, r_idx_nxt;
  logic [1:0]       c_idx, c_idx_nxt;
  logic [3:0]       settle_cnt, settle_cnt_nxt, settle_inc;
  logic [7:0]       deb_cnt, deb_cnt_nxt, deb_inc;
  logic [3:0]       row_nxt;
  logic [KEY_W-1:0] key_code_nxt;
  logic             key_valid_nxt, key_held_nxt, overrun_nxt;

  keypad_col_sync u_col_sync (
    .clk_sec (clk_sec),
    .rst_n   (rst_n),
    .col     (col),
    .col_s   (col_s)
  );

  assign settle_inc = (settle_cnt == 4'hF) ? settle_cnt : settle_cnt + 4'd1;
  assign deb_inc    = (deb_cnt == 8'hFF) ? deb_cnt : deb_cnt + 8'd1;

  always_ff @(posedge clk_sec) begin
    if (!rst_n) begin
      state      <= IDLE;
      r_idx      <= '0;
      c_idx      <= '0;
      settle_cnt <= '0;
      deb_cnt    <= '0;
      row        <= ROW_IDLE;
      key_code   <= '0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      r_idx      <= r_idx_nxt;
      c_idx      <= c_idx_nxt;
      settle_cnt <= settle_cnt_nxt;
      deb_cnt    <= deb_cnt_nxt;
      row        <= row_nxt;
      key_code   <= key_code_nxt;
      key_valid  <= key_valid_nxt;
      key_held   <= key_held_nxt;
      overrun    <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    r_idx_nxt      = r_idx;
    c_idx_nxt      = c_idx;
    settle_cnt_nxt = settle_cnt;
    deb_cnt_nxt    = deb_cnt;
    row_nxt        = row;
    key_code_nxt   = key_code;
    key_valid_nxt  = key_valid;
    key_held_nxt   = key_held;
    overrun_nxt    = 1'b0;

    if (key_valid && key_ready) begin
      key_valid_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        row_nxt     = ROW_IDLE;
        r_idx_nxt   = 2'd0;
        deb_cnt_nxt = '0;
        if (enable && (col_s != 4'd0)) begin
          if (settle_cnt == SETTLE_LAST) begin
            state_nxt      = SCAN;
            settle_cnt_nxt = '0;
            row_nxt        = idx_onehot(2'd0);
          end else begin
            settle_cnt_nxt = settle_inc;
          end
        end else begin
          settle_cnt_nxt = '0;
        end
      end

      SCAN: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_cnt_nxt = '0;
          // Multiple columns on one row cannot be resolved (ghosting), so skip the row.
          if (is_onehot(col_s)) begin
            c_idx_nxt   = onehot_idx(col_s);
            deb_cnt_nxt = '0;
            state_nxt   = DEBOUNCE;
          end else if (r_idx == 2'd3) begin
            state_nxt = IDLE;
            row_nxt   = ROW_IDLE;
          end else begin
            r_idx_nxt = r_idx + 2'd1;
            row_nxt   = idx_onehot(r_idx + 2'd1);
          end
        end else begin
          settle_cnt_nxt = settle_inc;
        end
      end

      DEBOUNCE: begin
        if (col_s == idx_onehot(c_idx)) begin
          if (deb_cnt == DEB_LAST) begin
            state_nxt   = REPORT;
            deb_cnt_nxt = '0;
          end else begin
            deb_cnt_nxt = deb_inc;
          end
        end else begin
          state_nxt   = IDLE;
          row_nxt     = ROW_IDLE;
          deb_cnt_nxt = '0;
        end
      end

      REPORT: begin
        // An unread code is kept; the new key is dropped and flagged instead.
        if (!key_valid || key_ready) begin
          key_code_nxt  = {r_idx, c_idx};
          key_valid_nxt = 1'b1;
        end else begin
          overrun_nxt = 1'b1;
        end
        key_held_nxt = 1'b1;
        deb_cnt_nxt  = '0;
        state_nxt    = RELEASE;
      end

      RELEASE: begin
        if (col_s == 4'd0) begin
          if (deb_cnt == DEB_LAST) begin
            key_held_nxt = 1'b0;
            deb_cnt_nxt  = '0;
            state_nxt    = IDLE;
            row_nxt      = ROW_IDLE;
          end else begin
            deb_cnt_nxt = deb_inc;
          end
        end else begin
          deb_cnt_nxt = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
        row_nxt   = ROW_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - self-checking bench for keypad_scan_ctrl with a keypad matrix model
module tb_keypad_scan_ctrl;

  localparam int S = 3;
  localparam int D = 4;

  logic        clk_sec = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_held;
  logic        overrun;
  logic [15:0] key_mask;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_ovr    = 0;
  logic [3:0] exp_q[$];
  bit         hold_prev = 1'b0;
  logic [3:0] hold_code = 4'd0;

  always #5 clk_sec = ~clk_sec;

  keypad_scan_ctrl #(.SETTLE_CYC(S), .DEBOUNCE_CYC(D)) dut (
    .clk_sec   (clk_sec),
    .rst_n     (rst_n),
    .enable    (enable),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  // Matrix: pressed key (r,c) connects row bit (3-r) to column bit (3-c).
  always_comb begin
    col = 4'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_mask[r*4+c] && row[3-r]) col[3-c] = 1'b1;
  end

  typedef struct {
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
    int         lat;
    bit         drop_en;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Observes the cycle about to be clocked, then advances to the next falling edge.
  task automatic tick();
    if (key_valid === 1'b1 && key_ready && rst_n) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%0h required=none", key_code);
      end else begin
        chk("sb_key_code", key_code, exp_q.pop_front());
      end
    end
    if (hold_prev) begin
      chk("hold_valid", key_valid, 1);
      chk("hold_code", key_code, hold_code);
    end
    hold_prev = (key_valid === 1'b1) && !key_ready && rst_n;
    hold_code = key_code;
    if (overrun === 1'b1) n_ovr++;
    @(posedge clk_sec);
    @(negedge clk_sec);
    cyc++;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return row !== 4'hF;
      1:       return key_valid === 1'b1;
      2:       return key_held === 1'b1;
      default: return key_held === 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int sel, input int max, output int n);
    n = 0;
    while (!cond(sel) && n < max) begin
      tick();
      n++;
    end
    if (!cond(sel)) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d required<%0d", nm, n, max);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int n, t_scan, bad, nv;
    logic [3:0] seq[$];
    logic [3:0] prev;
    logic [3:0] exp_seq[5];

    vecs[0] = '{2'd1, 2'd2, 4'h6, 11, 1'b0};
    vecs[1] = '{2'd0, 2'd0, 4'h0, 8,  1'b0};
    vecs[2] = '{2'd2, 2'd1, 4'h9, 14, 1'b0};
    vecs[3] = '{2'd3, 2'd3, 4'hF, 17, 1'b1};
    vecs[4] = '{2'd3, 2'd0, 4'hC, 17, 1'b0};
    exp_seq = '{4'h8, 4'h4, 4'h2, 4'h1, 4'hF};

    rst_n = 1'b0; enable = 1'b1; key_ready = 1'b1; key_mask = 16'd0;
    @(negedge clk_sec);
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_row", row, 4'hF);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_code", key_code, 0);

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (row !== 4'hF || key_valid !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    enable = 1'b0;
    key_mask = 16'd1 << 6;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (row !== 4'hF || key_valid !== 1'b0) bad++;
    end
    chk("enable_blocks_scan", bad, 0);
    key_mask = 16'd0;
    repeat (4) tick();
    enable = 1'b1;
    repeat (4) tick();

    for (int v = 0; v < 5; v++) begin
      key_mask = 16'd1 << (int'(vecs[v].r) * 4 + int'(vecs[v].c));
      exp_q.push_back(vecs[v].code);
      wait_for("scan_start", 0, 40, n);
      t_scan = cyc;
      if (vecs[v].drop_en) enable = 1'b0;
      wait_for("valid", 1, 60, n);
      chk("scan_to_valid_lat", cyc - t_scan, vecs[v].lat);
      chk("key_code", key_code, vecs[v].code);
      tick();
      chk("valid_one_cycle", key_valid, 0);
      chk("held_set", key_held, 1);
      repeat (40) tick();
      chk("no_repeat_valid", key_valid, 0);
      chk("held_while_pressed", key_held, 1);
      key_mask = 16'd0;
      wait_for("release", 3, 30, n);
      chk("release_lat", n, 2 + D);
      chk("row_idle_after", row, 4'hF);
      enable = 1'b1;
      repeat (3) tick();
    end

    bad = 0;
    for (int i = 0; i < 10; i++) begin
      key_mask = (i % 2 == 0) ? (16'd1 << 6) : 16'd0;
      tick();
      if (key_valid !== 1'b0 || row !== 4'hF) bad++;
    end
    chk("bounce_quiet", bad, 0);
    key_mask = 16'd1 << 6;
    exp_q.push_back(4'h6);
    nv = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (key_valid === 1'b1) nv++;
    end
    chk("bounce_one_valid", nv, 1);
    key_mask = 16'd0;
    wait_for("bounce_release", 3, 30, n);
    repeat (3) tick();

    key_mask = (16'd1 << 2) | (16'd1 << 3);
    prev = 4'hF;
    bad = 0;
    for (int i = 0; i < 40 && seq.size() < 5; i++) begin
      tick();
      if (key_valid !== 1'b0) bad++;
      if (row !== prev) begin
        seq.push_back(row);
        prev = row;
      end
    end
    chk("ghost_seq_len", seq.size(), 5);
    for (int i = 0; i < 5 && i < seq.size(); i++) chk("ghost_row_seq", seq[i], exp_seq[i]);
    chk("ghost_no_valid", bad, 0);
    key_mask = 16'd0;
    repeat (20) tick();

    key_ready = 1'b0;
    key_mask = 16'd1 << 0;
    exp_q.push_back(4'h0);
    wait_for("ovr_first", 1, 60, n);
    chk("ovr_first_code", key_code, 4'h0);
    wait_for("ovr_first_held", 2, 10, n);
    key_mask = 16'd0;
    wait_for("ovr_first_release", 3, 30, n);
    key_mask = 16'd1 << 15;
    wait_for("ovr_second_held", 2, 60, n);
    chk("overrun_pulse", overrun, 1);
    tick();
    chk("overrun_one_cycle", overrun, 0);
    chk("ovr_code_kept", key_code, 4'h0);
    chk("ovr_valid_kept", key_valid, 1);
    key_mask = 16'd0;
    wait_for("ovr_second_release", 3, 30, n);
    key_ready = 1'b1;
    tick();
    chk("ovr_drained", key_valid, 0);
    repeat (3) tick();

    key_ready = 1'b0;
    key_mask = 16'd1 << 9;
    wait_for("rst_rel_held", 2, 60, n);
    repeat (3) tick();
    chk("rst_rel_pre_valid", key_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("rst_rel_row", row, 4'hF);
    chk("rst_rel_held", key_held, 0);
    chk("rst_rel_valid", key_valid, 0);
    chk("rst_rel_code", key_code, 0);
    rst_n = 1'b1;
    key_ready = 1'b1;
    key_mask = 16'd0;
    repeat (10) tick();
    chk("rst_rel_idle_valid", key_valid, 0);

    chk("sb_drained", exp_q.size(), 0);
    chk("overrun_total", n_ovr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
